// File: rtl/score_tracker.sv
// Score tracker: counts goal-light wins per player, drives 7-segment digits
// and holds the playfield in reset between points and after match end.
module score_tracker #(
   parameter int NUM_PLAYERS = 2,
   parameter int MATCH_POINT = 7,
   parameter int COOLDOWN    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_PLAYERS-1:0]   round_win,
   input  logic                     new_match,
   output logic [4*NUM_PLAYERS-1:0] scores,
   output logic [7*NUM_PLAYERS-1:0] numbers,
   output logic                     reset_play,
   output logic                     match_over,
   output logic [1:0]               champion
);

   typedef enum logic [1:0] {
      S_PLAY,
      S_COOL,
      S_OVER
   } state_t;

   state_t state_q, state_d;

   logic [NUM_PLAYERS-1:0] rw_q;
   logic [NUM_PLAYERS-1:0] rise;
   logic [7:0]             cnt_q;
   logic [3:0]             sc_q [NUM_PLAYERS];
   logic                   award;
   logic                   hit;
   logic [1:0]             win_idx;
   logic                   cool_done;
   logic                   rp_d;
   logic                   mo_d;

   // Only a single clean rising edge scores; ties score nothing.
   always_comb begin
      rise    = round_win & ~rw_q;
      award   = (state_q == S_PLAY) && $onehot(rise);
      win_idx = 2'd0;
      hit     = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (rise[i]) begin
            win_idx = 2'(i);
            hit     = (sc_q[i] == 4'(MATCH_POINT - 1));
         end
      end
   end

   assign cool_done = (cnt_q == 8'(COOLDOWN - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_PLAY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_PLAY: if (award) state_d = hit ? S_OVER : S_COOL;
         S_COOL: if (cool_done) state_d = S_PLAY;
         S_OVER: if (new_match) state_d = S_COOL;
         default: state_d = S_PLAY;
      endcase
   end

   always_comb begin
      rp_d = (state_d != S_PLAY);
      mo_d = (state_d == S_OVER);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rw_q       <= '0;
         cnt_q      <= 8'd0;
         reset_play <= 1'b1;
         match_over <= 1'b0;
         champion   <= 2'd0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            sc_q[i] <= 4'd0;
         end
      end else begin
         rw_q       <= round_win;
         reset_play <= rp_d;
         match_over <= mo_d;
         if (state_q == S_COOL && !cool_done) begin
            cnt_q <= cnt_q + 8'd1;
         end else begin
            cnt_q <= 8'd0;
         end
         if (award && hit) begin
            champion <= win_idx;
         end
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (award && rise[i]) begin
               sc_q[i] <= sc_q[i] + 4'd1;
            end else if (state_q == S_OVER && new_match) begin
               sc_q[i] <= 4'd0;
            end
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0: seg7 = 7'b1000000;
         4'd1: seg7 = 7'b1111001;
         4'd2: seg7 = 7'b0100100;
         4'd3: seg7 = 7'b0110000;
         4'd4: seg7 = 7'b0011001;
         4'd5: seg7 = 7'b0010010;
         4'd6: seg7 = 7'b0000010;
         4'd7: seg7 = 7'b1111000;
         4'd8: seg7 = 7'b0000000;
         4'd9: seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_out
      assign scores[4*g +: 4]  = sc_q[g];
      assign numbers[7*g +: 7] = seg7(sc_q[g]);
   end

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: directed steps plus random play checked
// against a behavioural match model; a second 4-player instance.
module tb_score_tracker;

   localparam int MP = 7;
   localparam int CD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rw2;
   logic        nm2;
   logic [7:0]  scores2;
   logic [13:0] numbers2;
   logic        rp2, mo2;
   logic [1:0]  ch2;
   logic [3:0]  rw4;
   logic        nm4;
   logic [15:0] scores4;
   logic [27:0] numbers4;
   logic        rp4, mo4;
   logic [1:0]  ch4;

   int errs = 0;
   int checks = 0;

   // model state: mode 0=play 1=cooling 2=over
   logic [1:0] m_prev;
   int         m_sc [2];
   int         m_mode, m_left, m_ch;
   logic       m_rp, m_mo;

   score_tracker #(.NUM_PLAYERS(2), .MATCH_POINT(MP), .COOLDOWN(CD)) dut2 (
      .clk(clk), .reset(reset), .round_win(rw2), .new_match(nm2),
      .scores(scores2), .numbers(numbers2), .reset_play(rp2),
      .match_over(mo2), .champion(ch2)
   );

   score_tracker #(.NUM_PLAYERS(4), .MATCH_POINT(3), .COOLDOWN(CD)) dut4 (
      .clk(clk), .reset(reset), .round_win(rw4), .new_match(nm4),
      .scores(scores4), .numbers(numbers4), .reset_play(rp4),
      .match_over(mo4), .champion(ch4)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int v);
      case (v)
         0: seg = 7'b1000000;
         1: seg = 7'b1111001;
         2: seg = 7'b0100100;
         3: seg = 7'b0110000;
         4: seg = 7'b0011001;
         5: seg = 7'b0010010;
         6: seg = 7'b0000010;
         7: seg = 7'b1111000;
         8: seg = 7'b0000000;
         9: seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = 2'b00;
      m_sc[0] = 0;
      m_sc[1] = 0;
      m_mode = 0;
      m_left = 0;
      m_ch = 0;
      m_rp = 1'b1;
      m_mo = 1'b0;
   endtask

   task automatic model_edge();
      logic [1:0] r;
      int w;
      r = rw2 & ~m_prev;
      m_prev = rw2;
      if (m_mode == 0) begin
         if ($countones(r) == 1) begin
            w = r[1] ? 1 : 0;
            m_sc[w] = m_sc[w] + 1;
            if (m_sc[w] == MP) begin
               m_mode = 2;
               m_mo = 1'b1;
               m_ch = w;
            end else begin
               m_mode = 1;
               m_left = CD;
            end
         end
      end else if (m_mode == 1) begin
         m_left = m_left - 1;
         if (m_left == 0) m_mode = 0;
      end else if (nm2) begin
         m_sc[0] = 0;
         m_sc[1] = 0;
         m_mo = 1'b0;
         m_mode = 1;
         m_left = CD;
      end
      m_rp = (m_mode != 0);
   endtask

   task automatic check2(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s.score%0d", tag, i), 32'(scores2[4*i +: 4]),
             32'(m_sc[i]));
         chk($sformatf("%s.num%0d", tag, i), 32'(numbers2[7*i +: 7]),
             32'(seg(m_sc[i])));
      end
      chk({tag, ".reset_play"}, 32'(rp2), 32'(m_rp));
      chk({tag, ".match_over"}, 32'(mo2), 32'(m_mo));
      if (m_mo) chk({tag, ".champion"}, 32'(ch2), 32'(m_ch));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check2(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   initial begin
      int n;
      int guard;
      reset = 1'b0;
      rw2 = 2'b00;
      nm2 = 1'b0;
      rw4 = 4'b0000;
      nm4 = 1'b0;
      model_reset();
      #12;
      check2("reset");
      chk("reset.scores4", 32'(scores4), 32'h0);
      chk("reset.rp4", 32'(rp4), 32'h1);

      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("release.reset_play", 32'(rp2), 32'h1);
      tick("play0");

      // single pulse, then measure cooldown length
      rw2 = 2'b01;
      tick("pulse");
      rw2 = 2'b00;
      chk("pulse.score0", 32'(scores2[3:0]), 32'h1);
      chk("pulse.num0", 32'(numbers2[6:0]), 32'(7'b1111001));
      n = 0;
      guard = 0;
      while (rp2 === 1'b1 && guard < 10) begin
         n++;
         guard++;
         tick("cool");
      end
      chk("cool.length", 32'(n), 32'd4);

      // held input counts once
      rw2 = 2'b01;
      idle(20, "hold");
      rw2 = 2'b00;
      chk("hold.score0", 32'(scores2[3:0]), 32'h2);
      tick("hold_rel");

      // tie
      rw2 = 2'b11;
      tick("tie");
      chk("tie.scores", 32'(scores2), 32'h02);
      chk("tie.reset_play", 32'(rp2), 32'h0);
      rw2 = 2'b00;
      tick("tie_rel");

      // new_match outside OVER is ignored
      nm2 = 1'b1;
      tick("nm_play");
      nm2 = 1'b0;

      // edge during cooldown ignored
      rw2 = 2'b10;
      tick("p1pt");
      rw2 = 2'b00;
      tick("p1pt_rel");
      rw2 = 2'b01;
      tick("cool_ign");
      rw2 = 2'b00;
      idle(4, "cool_ign2");
      chk("cool_ign.score0", 32'(scores2[3:0]), 32'h2);

      // player 1 to match point
      for (int p = 0; p < 6; p++) begin
         rw2 = 2'b10;
         tick("p1run");
         rw2 = 2'b00;
         idle(5, "p1run_gap");
      end
      chk("over.match_over", 32'(mo2), 32'h1);
      chk("over.champion", 32'(ch2), 32'h1);
      chk("over.score1", 32'(scores2[7:4]), 32'h7);
      for (int k = 0; k < 8; k++) begin
         rw2 = 2'(k);
         tick("frozen");
      end
      rw2 = 2'b00;
      chk("frozen.scores", 32'(scores2), 32'h72);

      nm2 = 1'b1;
      tick("newmatch");
      nm2 = 1'b0;
      chk("newmatch.scores", 32'(scores2), 32'h0);
      chk("newmatch.match_over", 32'(mo2), 32'h0);
      n = 0;
      guard = 0;
      while (rp2 === 1'b1 && guard < 10) begin
         n++;
         guard++;
         tick("nm_cool");
      end
      chk("newmatch.cool_len", 32'(n), 32'd4);

      // random play against the model
      for (int k = 0; k < 400; k++) begin
         rw2 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         nm2 = ($urandom_range(0, 15) == 0);
         tick("rand");
      end
      rw2 = 2'b00;
      nm2 = 1'b0;
      tick("rand_end");

      // reset mid-cooldown
      guard = 0;
      while (m_mode != 0 && guard < 20) begin
         guard++;
         if (m_mode == 2) nm2 = 1'b1;
         tick("to_play");
         nm2 = 1'b0;
      end
      rw2 = 2'b01;
      tick("pre_rst_cool");
      rw2 = 2'b00;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check2("rst_cool");
      @(negedge clk);
      reset = 1'b1;
      tick("after_rst_cool");

      // drive to OVER, then reset asynchronously
      guard = 0;
      while (mo2 !== 1'b1 && guard < 20) begin
         guard++;
         rw2 = 2'b01;
         tick("p0run");
         rw2 = 2'b00;
         idle(5, "p0run_gap");
      end
      chk("p0over.match_over", 32'(mo2), 32'h1);
      chk("p0over.champion", 32'(ch2), 32'h0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_over.scores", 32'(scores2), 32'h0);
      chk("rst_over.numbers", 32'(numbers2), 32'({7'b1000000, 7'b1000000}));
      chk("rst_over.reset_play", 32'(rp2), 32'h1);
      chk("rst_over.match_over", 32'(mo2), 32'h0);
      chk("rst_over.champion", 32'(ch2), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick("after_rst_over");
      rw2 = 2'b10;
      tick("fresh_play");
      rw2 = 2'b00;
      chk("fresh_play.score1", 32'(scores2[7:4]), 32'h1);

      // four players, match point 3
      rw4 = 4'b0110;
      tick("tie4");
      chk("tie4.scores", 32'(scores4), 32'h0);
      rw4 = 4'b0000;
      tick("tie4_rel");
      for (int p = 0; p < 3; p++) begin
         rw4 = 4'b1000;
         tick("p3run");
         rw4 = 4'b0000;
         idle(5, "p3run_gap");
      end
      chk("p4.scores", 32'(scores4), 32'h3000);
      chk("p4.champion", 32'(ch4), 32'h3);
      chk("p4.match_over", 32'(mo4), 32'h1);
      chk("p4.num3", 32'(numbers4[27:21]), 32'(7'b0110000));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of players (legal 2..4).
REQ-002 SHALL have parameter MATCH_POINT, default 7, score that ends the match (legal 1..9).
REQ-003 SHALL have parameter COOLDOWN, default 4, cycles that reset_play stays asserted after a point (legal 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port round_win  input  NUM_PLAYERS  bit i set = player i reached the goal light this cycle.
REQ-007 SHALL have port new_match  input  1  one-cycle request to clear scores after match end.
REQ-008 SHALL have port scores  output  4*NUM_PLAYERS  binary score; player i in bits [4i+3:4i].
REQ-009 SHALL have port numbers  output  7*NUM_PLAYERS  active-low 7-segment digit per player; player i in bits [7i+6:7i].
REQ-010 SHALL have port reset_play  output  1  high while the playfield must re-centre.
REQ-011 SHALL have port match_over  output  1  high once a player reaches MATCH_POINT.
REQ-012 SHALL have port champion  output  2  index of the winning player, valid while match_over.

Function
REQ-013 SHALL implement states PLAY, COOLDOWN, OVER; the reset state is PLAY.
REQ-014 SHALL register round_win and detect rising edges per bit; a bit held high counts once only.
REQ-015 In PLAY, a point is awarded only when exactly one player's round_win bit rises in that cycle.
REQ-016 Simultaneous rising edges from two or more players SHALL be a tie: no score change, no state change.
REQ-017 On an award, the winner's score SHALL increment by 1 on the next edge, and the state SHALL move to COOLDOWN, or to OVER if the new score equals MATCH_POINT.
REQ-018 COOLDOWN SHALL last exactly COOLDOWN cycles, counted by an internal counter; round_win edges during it are ignored; it then returns to PLAY.
REQ-019 reset_play SHALL be registered and high for every cycle in COOLDOWN, and for the first cycle after reset deasserts.
REQ-020 Scores SHALL never exceed MATCH_POINT; there is no wrap.
REQ-021 In OVER: match_over=1; champion=winner index; reset_play=1; scores are frozen; round_win is ignored.
REQ-022 new_match SHALL be ignored outside OVER.
REQ-023 new_match in OVER SHALL zero all scores, clear match_over, and move to COOLDOWN for one full cooldown.
REQ-024 numbers SHALL encode the scores 0..9 as active-low segments: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 Player bits above NUM_PLAYERS-1 SHALL not exist; the champion output width stays 2 for any NUM_PLAYERS.
REQ-026 Every output SHALL come from a register, except numbers, which is decoded from the registered scores.

Reset
REQ-027 When reset=0, the block SHALL asynchronously force: state PLAY; all scores 0; all numbers 1000000; match_over 0; champion 0; cooldown counter 0; edge registers 0; reset_play 1.
REQ-028 Asserting reset mid-COOLDOWN or in OVER SHALL abandon that state immediately; the first edge after release behaves as fresh PLAY.

Verification
REQ-029 Release reset; pulse round_win=01 once -> scores[3:0]=1, numbers[6:0]=1111001, reset_play high exactly 4 cycles, then PLAY.
REQ-030 Hold round_win=01 for 20 cycles -> player 0 score rises by exactly 1.
REQ-031 Drive round_win=11 in one cycle -> both scores unchanged, reset_play stays 0.
REQ-032 Award player 1 seven separate points -> match_over=1, champion=1, score frozen at 7 under further round_win; pulse new_match -> scores 0, match_over 0, 4-cycle cooldown.
REQ-033 Drive round_win=01 during COOLDOWN -> ignored; assert reset in OVER -> all outputs take their REQ-027 values at once, without waiting for clk.
REQ-034 Run with NUM_PLAYERS=4, MATCH_POINT=3: player 3 wins 3 points -> champion=3, scores=0x3000.
